// File: rtl/mux_seq_pkg.sv
// Shared constants for the sequential add/sub controller.
package mux_seq_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL_A = 2'd1;
  localparam logic [1:0] ST_SEL_B = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mux_seq_addsub_8b_addsub_core.sv
// Combinational add/sub with carry and signed overflow flags.
// MUX_SEQ_SAT_EN: unsigned saturation of sum; flags stay raw.
module addsub_core
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;

  assign b_eff = sub ? ~b : b;
  assign raw   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign cout  = raw[WIDTH];
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef MUX_SEQ_SAT_EN
  always_comb begin
    sum = raw[WIDTH-1:0];
    if (!sub && raw[WIDTH])
      sum = {WIDTH{1'b1}};
    else if (sub && !raw[WIDTH])
      sum = {WIDTH{1'b0}};
  end
`else
  assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/mux_seq_addsub_8b.sv
// Steers an upstream 2:1 mux to fetch A then B and returns A+B / A-B.
// Saturation option: MUX_SEQ_SAT_EN (see addsub_core).
module mux_seq_addsub_8b
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] Y,
  output logic             S,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  logic [1:0]       state_q, state_d;
  logic             s_q, s_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] c_sum;
  logic             c_cout;
  logic             c_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (opa_q),
    .b    (Y),
    .sub  (sub_q),
    .sum  (c_sum),
    .cout (c_cout),
    .ovf  (c_ovf)
  );

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    opa_d   = opa_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEL_A;
          sub_d   = sub;
        end
      end
      ST_SEL_A: begin
        opa_d   = Y;
        state_d = ST_SEL_B;
      end
      ST_SEL_B: begin
        sum_d   = c_sum;
        cout_d  = c_cout;
        ovf_d   = c_ovf;
        vld_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // start only counts once the result is taken
        if (out_ready) begin
          vld_d = 1'b0;
          if (start) begin
            state_d = ST_SEL_A;
            sub_d   = sub;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_d = (state_d == ST_SEL_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= 1'b0;
      sub_q   <= 1'b0;
      opa_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      opa_q   <= opa_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign S         = s_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = vld_q;
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule

// File: doc/mux_seq_addsub_8b.md
Name: mux_seq_addsub_8b

Overview:
Sequential add/subtract controller that sits directly downstream of the 8-bit 2:1 operand mux (mux2_8b) and drives its select line.
- Steers S to fetch operand A, then operand B, through the shared mux output Y.
- Computes A+B or A-B and presents a registered result with a valid/ready handshake.
- Lets one narrow datapath port serve both operands of the lab adder.

Parameters:
WIDTH, 8, operand/result width in bits (all tests at 8).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled only when accepted (see Behaviour).
sub  input  1  operation select, captured with start: 0 = A+B, 1 = A-B.
Y  input  WIDTH  mux output; A when S=0, B when S=1.
S  output  1  registered mux select driven to the mux.
busy  output  1  high in SEL_A, SEL_B and DONE.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
SUM  output  WIDTH  registered result.
COUT  output  1  add: carry out; sub: 1 = no borrow (A>=B unsigned).
OVF  output  1  signed two's-complement overflow of the operation.

Behaviour:
- Reset (async, rst_n=0) → state IDLE; S=0, busy=0, out_valid=0, SUM=0, COUT=0, OVF=0, internal opa=0, sub_q=0. Applies immediately, including mid-operation; any in-flight op is discarded.
- FSM states, 2-bit encoded:
  - IDLE: start=1 at a clock edge → SEL_A and capture sub_q=sub. Otherwise stay in IDLE.
  - SEL_A: S=0. At the edge, opa←Y → SEL_B.
  - SEL_B: S=1. At the edge:
    - {COUT,SUM} ← opa + (sub_q ? ~Y : Y) + sub_q
    - OVF ← (opa[MSB] == (sub_q ? ~Y[MSB] : Y[MSB])) && (SUM_new[MSB] != opa[MSB])
    - out_valid←1 → DONE.
  - DONE: out_valid=1 and SUM/COUT/OVF held stable.
    - out_ready=1 and start=0 → IDLE.
    - out_ready=1 and start=1 → SEL_A, capturing the new sub (back-to-back).
    - out_ready=0 → stay in DONE; start is ignored.
- S is a flop: 1 exactly while state==SEL_B, else 0. Y is assumed combinationally valid in the same cycle S is presented.
- Latency: start accepted at edge N → out_valid high after edge N+2. Throughput is one result per 3 cycles with back-to-back.
- out_valid drops on the edge where out_ready is sampled high. SUM/COUT/OVF keep their last values until overwritten in the next SEL_B.
- start while busy (SEL_A/SEL_B) is ignored; no queuing.
- Widths: internal sum is WIDTH+1 bits, with COUT as the MSB. No X on any output after reset.

Optional Feature:
MUX_SEQ_SAT_EN
- Defined → unsigned saturation on SUM:
  - add with carry → SUM = all-ones.
  - sub with borrow (COUT=0) → SUM = 0.
  - COUT and OVF still report raw, unsaturated flags.
- Undefined → SUM is the wrapped modulo-2^WIDTH result.

Decomposition:
- Shared package mux_seq_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SEL_A=2'd1, ST_SEL_B=2'd2, ST_DONE=2'd3.
  - default width constant (8).
- One natural combinational sub-module: addsub_core.
  - Inputs: a, b, sub.
  - Outputs: sum, cout, ovf.
  - Saturation is applied inside it under MUX_SEQ_SAT_EN.
- FSM, S flop and result registers stay in the top.

Test Plan:
- Add, mixed sign: A=0x3C, B=0xA5, sub=0, pulse start → S=0 then 1 on successive cycles; out_valid 3rd cycle; SUM=0xE1, COUT=0, OVF=0.
- Carry wrap: A=0xFF, B=0x01, sub=0 → SUM=0x00, COUT=1, OVF=0. With MUX_SEQ_SAT_EN: SUM=0xFF.
- Signed overflow and subtract:
  - A=0x7F, B=0x01 add → SUM=0x80, COUT=0, OVF=1.
  - A=0x01, B=0x02 sub → SUM=0xFF, COUT=0, OVF=0; with MUX_SEQ_SAT_EN: SUM=0x00.
- Backpressure: complete an op, hold out_ready=0 for 5 cycles while pulsing start.
  - out_valid stays 1, SUM stable, no new op starts.
  - Raise out_ready with start=1 → next op enters SEL_A on that edge.
- Reset mid-op: assert rst_n=0 during SEL_B (between edges) → immediately S=0, busy=0, out_valid=0, SUM=0, COUT=0, OVF=0. After release, a fresh A=0x10, B=0x20 add → SUM=0x30.
